// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions: register-address width, FSM state encodings, control bundle.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
//
// Defines `LEN_REG_ADDRESS (register-file address width) unless the ISA build already provides it.
// Contents:
//   REG_ADDR_W  - register address width as a package constant
//   reg_addr_t  - register address type
//   state_e     - SRAM wait FSM states (IDLE=0, ACCESS=1, DONE=2)
//   ctrl_t      - packed bundle of the stage freeze/flush controls
//   addr_hit()  - enabled destination/source compare used by hazard detection

`ifndef LEN_REG_ADDRESS
`define LEN_REG_ADDRESS 5
`endif

package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W = `LEN_REG_ADDRESS;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Freeze/flush controls in the order they are driven onto the top-level ports.
  typedef struct packed {
    logic freeze_pc;
    logic freeze_if;
    logic flush_if;
    logic freeze_id;
    logic flush_id;
    logic freeze_exe;
    logic freeze_mem;
    logic branch_taken_out;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // True when a writing stage targets the register being read.
  function automatic logic addr_hit(input logic wr_en, input reg_addr_t dest, input reg_addr_t src);
    return wr_en & (dest == src);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// RAW hazard detector between the ID-stage sources and the EXE/MEM destinations.
// Latency: combinational, 0 cycles.
// Backpressure: none; the result only feeds the stall/flush priority mux in pipeline_ctrl.
//
// Build option: FORWARDING_EN. When defined, the bypass network covers every RAW case
// except a load still in EXE, so only load-use hazards are reported.
// Ports:
//   id_src1/id_src2, id_two_src, id_valid  - ID-stage operand info
//   exe_dest, exe_wb_en, exe_mem_read       - EXE-stage writer
//   mem_dest, mem_wb_en                     - MEM-stage writer
//   hazard                                  - RAW hazard present

module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  output logic                  hazard
);

`ifdef FORWARDING_EN

  // Only a load in EXE cannot be bypassed; its data does not exist until MEM completes.
  logic src1_load_hit;
  logic src2_load_hit;

  assign src1_load_hit = addr_hit(exe_mem_read, exe_dest, id_src1);
  assign src2_load_hit = id_two_src & addr_hit(exe_mem_read, exe_dest, id_src2);
  assign hazard        = id_valid & (src1_load_hit | src2_load_hit);

  // MEM-stage writer and EXE writeback enable are covered by forwarding here.
  logic unused_fwd;
  assign unused_fwd = exe_wb_en ^ mem_wb_en ^ (^mem_dest);

`else

  logic src1_hit;
  logic src2_hit;

  assign src1_hit = addr_hit(exe_wb_en, exe_dest, id_src1) |
                    addr_hit(mem_wb_en, mem_dest, id_src1);
  assign src2_hit = id_two_src &
                    (addr_hit(exe_wb_en, exe_dest, id_src2) |
                     addr_hit(mem_wb_en, mem_dest, id_src2));
  assign hazard   = id_valid & (src1_hit | src2_hit);

  // Load-ness only matters when forwarding hides the other RAW cases.
  logic unused_nofwd;
  assign unused_nofwd = exe_mem_read;

`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: SRAM wait FSM, branch flush and RAW-hazard bubble for the 5-stage pipe.
// Latency: 0 cycles input-to-control (controls are combinational from FSM state and inputs).
// Backpressure: a MEM load/store freezes every stage for SRAM_WAIT_CYCLES cycles, then pulses mem_ready.
//
// Build option: FORWARDING_EN (passed to hazard_detect) restricts hazards to load-use only.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset (forces all outputs low)
//   id_* / exe_* / mem_* inputs    - pipeline stage state used for hazard and memory sequencing
//   branch_taken                   - EXE resolved a taken branch
//   freeze_* / flush_*             - stage register controls
//   sram_en, mem_ready             - SRAM strobe and one-cycle completion pulse
//   branch_taken_out, hazard       - gated branch select and raw hazard visibility

module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int SRAM_WAIT_CYCLES = 3,
  parameter int CNT_W            = $clog2(SRAM_WAIT_CYCLES + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [`LEN_REG_ADDRESS-1:0] id_src1,
  input  logic [`LEN_REG_ADDRESS-1:0] id_src2,
  input  logic                        id_two_src,
  input  logic                        id_valid,
  input  logic [`LEN_REG_ADDRESS-1:0] exe_dest,
  input  logic                        exe_wb_en,
  input  logic                        exe_mem_read,
  input  logic [`LEN_REG_ADDRESS-1:0] mem_dest,
  input  logic                        mem_wb_en,
  input  logic                        mem_read,
  input  logic                        mem_write,
  input  logic                        branch_taken,
  output logic                        freeze_pc,
  output logic                        freeze_if,
  output logic                        flush_if,
  output logic                        freeze_id,
  output logic                        flush_id,
  output logic                        freeze_exe,
  output logic                        freeze_mem,
  output logic                        sram_en,
  output logic                        mem_ready,
  output logic                        branch_taken_out,
  output logic                        hazard
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRAM_WAIT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic  mem_req;
  logic  mem_stall;
  logic  sram_act;
  logic  ready_act;
  logic  raw_hazard;
  ctrl_t ctrl;

  assign mem_req = mem_read | mem_write;

  hazard_detect u_hazard_detect (
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .id_valid     (id_valid),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_read (exe_mem_read),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .hazard       (raw_hazard)
  );

  // SRAM wait sequencing. The request cycle in IDLE is already the first stall
  // cycle, so cnt counts completed stall cycles and ACCESS leaves after the last.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    sram_act  = 1'b0;
    ready_act = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          mem_stall = 1'b1;
          sram_act  = 1'b1;
          cnt_d     = CNT_ONE;
          state_d   = (SRAM_WAIT_CYCLES == 1) ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        mem_stall = 1'b1;
        sram_act  = 1'b1;
        cnt_d     = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Pipeline advances at the end of this cycle, so the completed access
        // has left MEM before IDLE samples mem_read/mem_write again.
        ready_act = 1'b1;
        cnt_d     = '0;
        state_d   = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Priority: memory stall > taken branch > RAW hazard.
  // A branch seen during a stall is held frozen in EXE and honoured afterwards;
  // a hazard under a taken branch is moot because the reader is being flushed.
  always_comb begin
    ctrl = CTRL_NONE;
    if (mem_stall) begin
      ctrl.freeze_pc  = 1'b1;
      ctrl.freeze_if  = 1'b1;
      ctrl.freeze_id  = 1'b1;
      ctrl.freeze_exe = 1'b1;
      ctrl.freeze_mem = 1'b1;
    end else if (branch_taken) begin
      ctrl.flush_if         = 1'b1;
      ctrl.flush_id         = 1'b1;
      ctrl.branch_taken_out = 1'b1;
    end else if (raw_hazard) begin
      // Hold PC and IF/ID, push a bubble into EXE.
      ctrl.freeze_pc = 1'b1;
      ctrl.freeze_if = 1'b1;
      ctrl.flush_id  = 1'b1;
    end
  end

  assign {freeze_pc, freeze_if, flush_if, freeze_id, flush_id,
          freeze_exe, freeze_mem, branch_taken_out} = rst ? CTRL_NONE : ctrl;

  assign sram_en   = ~rst & sram_act;
  assign mem_ready = ~rst & ready_act;
  assign hazard    = ~rst & raw_hazard;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with SRAM_WAIT_CYCLES=3; inputs change on the falling edge
// and the combinational controls are sampled 1 ns later, well away from the rising edge.
// Expected control vectors are hand-built constants.

module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  logic            clk;
  logic            rst;
  logic [REG_ADDR_W-1:0] id_src1, id_src2, exe_dest, mem_dest;
  logic            id_two_src, id_valid, exe_wb_en, exe_mem_read;
  logic            mem_wb_en, mem_read, mem_write, branch_taken;
  logic            freeze_pc, freeze_if, flush_if, freeze_id, flush_id;
  logic            freeze_exe, freeze_mem, sram_en, mem_ready, branch_taken_out, hazard;

  int n_cmp;
  int n_bad;

  pipeline_ctrl #(.SRAM_WAIT_CYCLES(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_src1          (id_src1),
    .id_src2          (id_src2),
    .id_two_src       (id_two_src),
    .id_valid         (id_valid),
    .exe_dest         (exe_dest),
    .exe_wb_en        (exe_wb_en),
    .exe_mem_read     (exe_mem_read),
    .mem_dest         (mem_dest),
    .mem_wb_en        (mem_wb_en),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .branch_taken     (branch_taken),
    .freeze_pc        (freeze_pc),
    .freeze_if        (freeze_if),
    .flush_if         (flush_if),
    .freeze_id        (freeze_id),
    .flush_id         (flush_id),
    .freeze_exe       (freeze_exe),
    .freeze_mem       (freeze_mem),
    .sram_en          (sram_en),
    .mem_ready        (mem_ready),
    .branch_taken_out (branch_taken_out),
    .hazard           (hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit order: pc if flif id flid exe mem sram rdy bto haz
  logic [10:0] ctl;
  assign ctl = {freeze_pc, freeze_if, flush_if, freeze_id, flush_id,
                freeze_exe, freeze_mem, sram_en, mem_ready, branch_taken_out, hazard};

  localparam logic [10:0] C_ZERO     = 11'b0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [10:0] C_STALL    = 11'b1_1_0_1_0_1_1_1_0_0_0;
  localparam logic [10:0] C_STALL_HZ = 11'b1_1_0_1_0_1_1_1_0_0_1;
  localparam logic [10:0] C_READY    = 11'b0_0_0_0_0_0_0_0_1_0_0;
  localparam logic [10:0] C_RDY_BR   = 11'b0_0_1_0_1_0_0_0_1_1_0;
  localparam logic [10:0] C_HAZ      = 11'b1_1_0_0_1_0_0_0_0_0_1;
  localparam logic [10:0] C_BR_HAZ   = 11'b0_0_1_0_1_0_0_0_0_1_1;

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_src1 = '0; id_src2 = '0; exe_dest = '0; mem_dest = '0;
    id_two_src = 1'b0; id_valid = 1'b0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
    mem_wb_en = 1'b0; mem_read = 1'b0; mem_write = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    clear_inputs();

    // Reset forces everything low even with a request and a hazard present.
    mem_read = 1'b1; id_valid = 1'b1; id_src1 = 5'd4; exe_dest = 5'd4; exe_wb_en = 1'b1;
    next_cycle(); #1 check("reset_forced", ctl, C_ZERO);
    next_cycle(); clear_inputs(); rst = 1'b0;
    #1 check("idle", ctl, C_ZERO);

    // Load: 3 stall cycles, then one ready cycle with no freezes, then idle.
    next_cycle(); mem_read = 1'b1;
    #1 check("load_stall1", ctl, C_STALL);
    next_cycle(); #1 check("load_stall2", ctl, C_STALL);
    next_cycle(); #1 check("load_stall3", ctl, C_STALL);
    next_cycle(); #1 check("load_done", ctl, C_READY);
    next_cycle(); mem_read = 1'b0;
    #1 check("load_back_idle", ctl, C_ZERO);

    // EXE-stage RAW on src1.
    next_cycle(); id_valid = 1'b1; id_src1 = 5'd4; exe_dest = 5'd4; exe_wb_en = 1'b1;
`ifdef FORWARDING_EN
    #1 check("exe_raw_fwd", ctl, C_ZERO);
`else
    #1 check("exe_raw", ctl, C_HAZ);
`endif
    next_cycle(); exe_mem_read = 1'b1;
    #1 check("load_use", ctl, C_HAZ);

    // Taken branch overrides the hazard bubble.
    next_cycle(); branch_taken = 1'b1;
    #1 check("branch_over_haz", ctl, C_BR_HAZ);

    // Hazard output stays visible underneath a memory stall.
    next_cycle(); branch_taken = 1'b0; mem_write = 1'b1;
    #1 check("stall_hazard_vis", ctl, C_STALL_HZ);
    next_cycle(); #1 check("stall_hz2", ctl, C_STALL_HZ);
    next_cycle(); #1 check("stall_hz3", ctl, C_STALL_HZ);
    next_cycle(); clear_inputs(); mem_write = 1'b1;
    #1 check("stall_hz_done", ctl, C_READY);
    next_cycle(); clear_inputs();
    #1 check("idle2", ctl, C_ZERO);

    // Branch during access is held off until the DONE cycle.
    next_cycle(); mem_write = 1'b1; branch_taken = 1'b1;
    #1 check("br_stall1", ctl, C_STALL);
    next_cycle(); #1 check("br_stall2", ctl, C_STALL);
    next_cycle(); #1 check("br_stall3", ctl, C_STALL);
    next_cycle(); #1 check("br_done", ctl, C_RDY_BR);
    next_cycle(); clear_inputs();
    #1 check("idle3", ctl, C_ZERO);

    // Reset in the second ACCESS cycle aborts with no ready pulse.
    next_cycle(); mem_write = 1'b1;
    #1 check("abort_stall1", ctl, C_STALL);
    next_cycle(); #1 check("abort_stall2", ctl, C_STALL);
    next_cycle(); rst = 1'b1;
    #1 check("abort_rst", ctl, C_ZERO);
    next_cycle(); rst = 1'b0; mem_write = 1'b0;
    #1 check("abort_no_ready", ctl, C_ZERO);
    next_cycle(); mem_write = 1'b1;
    #1 check("fresh_stall1", ctl, C_STALL);
    next_cycle(); #1 check("fresh_stall2", ctl, C_STALL);
    next_cycle(); #1 check("fresh_stall3", ctl, C_STALL);
    next_cycle(); #1 check("fresh_done", ctl, C_READY);
    next_cycle(); clear_inputs();
    #1 check("idle4", ctl, C_ZERO);

    // src2 only counts when the instruction actually reads it.
    next_cycle(); id_valid = 1'b1; id_src1 = 5'd1; id_src2 = 5'd7; mem_dest = 5'd7; mem_wb_en = 1'b1;
    #1 check("src2_unused", ctl, C_ZERO);
    next_cycle(); id_two_src = 1'b1;
`ifdef FORWARDING_EN
    #1 check("src2_mem_fwd", ctl, C_ZERO);
`else
    #1 check("src2_mem_raw", ctl, C_HAZ);
`endif

    // No hazard without a valid ID instruction.
    next_cycle(); id_valid = 1'b0;
    #1 check("id_invalid", ctl, C_ZERO);

    // MEM writer with wb disabled does not create a hazard.
    next_cycle(); id_valid = 1'b1; mem_wb_en = 1'b0;
    #1 check("mem_wb_off", ctl, C_ZERO);

    // Plain taken branch without hazard.
    next_cycle(); clear_inputs(); branch_taken = 1'b1;
    #1 check("branch_only", ctl, 11'b0_0_1_0_1_0_0_0_0_1_0);

    next_cycle(); clear_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
